// File: rtl/pool_ifm_loader.sv
// ---------------------------------------------------------------------------
// pool_ifm_loader
//
// Producer side of the pooling IFM row handshake. Pixels arrive on an
// upstream valid/ready stream and are banked into one of two IFM_SIZE-deep
// row buffers (ping-pong). Once a row is complete, the bank is presented to
// the pooling controller via 'full', and the controller pulls the row out one
// pixel per 'ifm_read' cycle while the other bank refills.
//
// Ports
//   clk1          in   system clock, all logic on its rising edge
//   rst_n         in   asynchronous, active-low reset
//   in_valid      in   upstream pixel valid
//   in_data       in   upstream pixel
//   in_ready      out  write bank has room (combinational)
//   ifm_read      in   controller consumes one pixel this cycle
//   full          out  read bank holds a complete row (combinational)
//   ifm_out       out  registered pixel, one cycle after ifm_read
//   ifm_out_valid out  ifm_out holds a pixel that was actually read
//   row_last      out  with ifm_out_valid: last pixel of a row
//   frame_done    out  1-cycle pulse with the last pixel of the frame
//   underrun      out  sticky: ifm_read seen while full was low
// ---------------------------------------------------------------------------
module pool_ifm_loader #(
  parameter int IFM_SIZE   = 9,
  parameter int CI         = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  ifm_read,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] ifm_out,
  output logic                  ifm_out_valid,
  output logic                  row_last,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int CW  = $clog2(IFM_SIZE);
  localparam int CHW = $clog2(CI) + 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(IFM_SIZE - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CI - 1);

  // Two row banks; contents are never reset, only the full flags are.
  logic [DATA_WIDTH-1:0] mem [0:1][0:IFM_SIZE-1];

  logic [1:0]     bank_full_reg, bank_full_next;
  logic           wb_reg, wb_next;
  logic           rb_reg, rb_next;
  logic [CW-1:0]  wcnt_reg, wcnt_next;
  logic [CW-1:0]  rcnt_reg, rcnt_next;
  logic [CW-1:0]  row_cnt_reg, row_cnt_next;
  logic [CHW-1:0] ch_cnt_reg, ch_cnt_next;

  logic [DATA_WIDTH-1:0] ifm_out_reg;
  logic                  ifm_out_valid_reg;
  logic                  row_last_reg;
  logic                  frame_done_reg;
  logic                  underrun_reg;

  logic wr_fire;
  logic rd_fire;
  logic rd_underrun;
  logic rd_last;
  logic frame_wrap;

  assign in_ready    = !bank_full_reg[wb_reg];
  assign full        = bank_full_reg[rb_reg];

  assign wr_fire     = in_valid && in_ready;
  assign rd_fire     = ifm_read && full;
  assign rd_underrun = ifm_read && !full;
  assign rd_last     = rd_fire && (rcnt_reg == CNT_LAST);
  assign frame_wrap  = rd_last && (row_cnt_reg == CNT_LAST) && (ch_cnt_reg == CH_LAST);

  // Next-state for pointers, counters and bank flags. A write can only fill
  // the write bank and a read can only release the read bank; when both
  // happen on one edge they target different banks (the write bank is never
  // full while being written, the read bank is always full while read), so
  // the two flag updates never collide.
  always_comb begin
    bank_full_next = bank_full_reg;
    wb_next        = wb_reg;
    rb_next        = rb_reg;
    wcnt_next      = wcnt_reg;
    rcnt_next      = rcnt_reg;
    row_cnt_next   = row_cnt_reg;
    ch_cnt_next    = ch_cnt_reg;

    if (wr_fire) begin
      if (wcnt_reg == CNT_LAST) begin
        wcnt_next              = '0;
        wb_next                = !wb_reg;
        bank_full_next[wb_reg] = 1'b1;
      end else begin
        wcnt_next = wcnt_reg + CW'(1);
      end
    end

    if (rd_fire) begin
      if (rcnt_reg == CNT_LAST) begin
        rcnt_next              = '0;
        rb_next                = !rb_reg;
        bank_full_next[rb_reg] = 1'b0;
        if (row_cnt_reg == CNT_LAST) begin
          row_cnt_next = '0;
          ch_cnt_next  = (ch_cnt_reg == CH_LAST) ? '0 : ch_cnt_reg + CHW'(1);
        end else begin
          row_cnt_next = row_cnt_reg + CW'(1);
        end
      end else begin
        rcnt_next = rcnt_reg + CW'(1);
      end
    end
  end

  // Row bank write port.
  always_ff @(posedge clk1) begin
    if (wr_fire) begin
      mem[wb_reg][wcnt_reg] <= in_data;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_reg     <= '0;
      wb_reg            <= 1'b0;
      rb_reg            <= 1'b0;
      wcnt_reg          <= '0;
      rcnt_reg          <= '0;
      row_cnt_reg       <= '0;
      ch_cnt_reg        <= '0;
      ifm_out_reg       <= '0;
      ifm_out_valid_reg <= 1'b0;
      row_last_reg      <= 1'b0;
      frame_done_reg    <= 1'b0;
      underrun_reg      <= 1'b0;
    end else begin
      bank_full_reg     <= bank_full_next;
      wb_reg            <= wb_next;
      rb_reg            <= rb_next;
      wcnt_reg          <= wcnt_next;
      rcnt_reg          <= rcnt_next;
      row_cnt_reg       <= row_cnt_next;
      ch_cnt_reg        <= ch_cnt_next;
      ifm_out_valid_reg <= rd_fire;
      row_last_reg      <= rd_last;
      frame_done_reg    <= frame_wrap;
      // ifm_out holds its last value when nothing is read.
      if (rd_fire) begin
        ifm_out_reg <= mem[rb_reg][rcnt_reg];
      end
      if (rd_underrun) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign ifm_out       = ifm_out_reg;
  assign ifm_out_valid = ifm_out_valid_reg;
  assign row_last      = row_last_reg;
  assign frame_done    = frame_done_reg;
  assign underrun      = underrun_reg;

endmodule

// File: tb/tb_pool_ifm_loader.sv
// ---------------------------------------------------------------------------
// tb_pool_ifm_loader
//
// Self-checking bench for pool_ifm_loader: a table of single-cycle vectors
// for the basic fill/drain row, followed by hand-written sequences for
// backpressure, a full frame, underrun, mid-row reset and random stalls.
// ---------------------------------------------------------------------------
module tb_pool_ifm_loader;

  localparam int IFM_SIZE = 9;
  localparam int CI       = 3;
  localparam int DW       = 8;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ifm_read;
  logic          full;
  logic [DW-1:0] ifm_out;
  logic          ifm_out_valid;
  logic          row_last;
  logic          frame_done;
  logic          underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk1 = ~clk1;

  pool_ifm_loader #(
    .IFM_SIZE  (IFM_SIZE),
    .CI        (CI),
    .DATA_WIDTH(DW)
  ) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ifm_read     (ifm_read),
    .full         (full),
    .ifm_out      (ifm_out),
    .ifm_out_valid(ifm_out_valid),
    .row_last     (row_last),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rd;
    logic          e_ready;
    logic          e_full;
    logic          e_ov;
    logic [DW-1:0] e_out;
    logic          e_last;
    logic          e_fd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic rd,
                              input logic e_ready, input logic e_full, input logic e_ov,
                              input logic [DW-1:0] e_out, input logic e_last, input logic e_fd);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd;
    t.e_ready = e_ready; t.e_full = e_full; t.e_ov = e_ov;
    t.e_out = e_out; t.e_last = e_last; t.e_fd = e_fd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ifm_read = 1'b0;
    step();
    step();
    chk("rst_full",       32'(full),          32'd0);
    chk("rst_ifm_out",    32'(ifm_out),       32'd0);
    chk("rst_out_valid",  32'(ifm_out_valid), 32'd0);
    chk("rst_row_last",   32'(row_last),      32'd0);
    chk("rst_frame_done", 32'(frame_done),    32'd0);
    chk("rst_underrun",   32'(underrun),      32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready",   32'(in_ready),      32'd1);
  endtask

  task automatic write_px(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    ifm_read = 1'b0;
    chk("wr_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic read_px(input string name, input logic [DW-1:0] exp, input logic exp_last);
    ifm_read = 1'b1;
    chk({name, "_full"}, 32'(full), 32'd1);
    step();
    ifm_read = 1'b0;
    chk({name, "_valid"}, 32'(ifm_out_valid), 32'd1);
    chk({name, "_data"},  32'(ifm_out),       32'(exp));
    chk({name, "_last"},  32'(row_last),      32'(exp_last));
    $display("read %s pixel %0d last=%0d", name, ifm_out, row_last);
  endtask

  initial begin
    int wr, rd, cyc, fd_cnt, fd_at, rl_cnt, pushed, popped;
    logic wrote, rd_en;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_px;

    // ---------------- table: one row in, one row out ----------------
    for (int i = 0; i < IFM_SIZE; i++)
      tbl[i] = mk(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int r = 0; r < IFM_SIZE; r++)
      tbl[IFM_SIZE + r] = mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'(r + 1),
                             (r == IFM_SIZE - 1), 1'b0);
    tbl[18] = mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    do_reset();
    for (int k = 0; k < 19; k++) begin
      in_valid = tbl[k].v;
      in_data  = tbl[k].d;
      ifm_read = tbl[k].rd;
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[k].e_ready));
      chk("tbl_full",     32'(full),     32'(tbl[k].e_full));
      step();
      chk("tbl_out_valid", 32'(ifm_out_valid), 32'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk("tbl_ifm_out", 32'(ifm_out), 32'(tbl[k].e_out));
      chk("tbl_row_last",   32'(row_last),   32'(tbl[k].e_last));
      chk("tbl_frame_done", 32'(frame_done), 32'(tbl[k].e_fd));
      $display("vec %0d: v=%0d d=%0d rd=%0d -> ov=%0d out=%0d last=%0d",
               k, tbl[k].v, tbl[k].d, tbl[k].rd, ifm_out_valid, ifm_out, row_last);
    end
    in_valid = 1'b0;
    ifm_read = 1'b0;

    // ---------------- both banks full, upstream stalls ----------------
    do_reset();
    for (int i = 1; i <= 2 * IFM_SIZE; i++) write_px(8'(100 + i));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_full",         32'(full),     32'd1);
    in_valid = 1'b1;
    in_data  = 8'd200;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_held_ready", 32'(in_ready), 32'd0);
    end
    for (int r = 1; r <= IFM_SIZE; r++) begin
      chk("bp_ready_during_read", 32'(in_ready), 32'd0);
      ifm_read = 1'b1;
      step();
      chk("bp_rd_data", 32'(ifm_out), 32'(100 + r));
      $display("read bp pixel %0d", ifm_out);
    end
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_full_stays", 32'(full),     32'd1);
    // The held 200 is written on the same edge as the first read of bank 1.
    for (int r = 10; r <= 2 * IFM_SIZE; r++) begin
      step();
      in_valid = 1'b0;
      chk("bp_rd2_data", 32'(ifm_out), 32'(100 + r));
      chk("bp_rd2_last", 32'(row_last), 32'(r == 2 * IFM_SIZE));
    end
    ifm_read = 1'b0;
    chk("bp_full_drop", 32'(full), 32'd0);
    for (int i = 1; i < IFM_SIZE; i++) write_px(8'(200 + i));
    for (int r = 0; r < IFM_SIZE; r++) read_px("bp_held", 8'(200 + r), (r == IFM_SIZE - 1));

    // ---------------- full frame, continuous write and read ----------------
    do_reset();
    wr = 0; rd = 0; cyc = 0; fd_cnt = 0; fd_at = -1; rl_cnt = 0;
    while (rd < IFM_SIZE * IFM_SIZE * CI && cyc < 1000) begin
      in_valid = (wr < IFM_SIZE * IFM_SIZE * CI);
      in_data  = 8'(wr + 1);
      ifm_read = full;
      wrote    = in_valid && in_ready;
      step();
      cyc++;
      if (wrote) wr++;
      if (ifm_out_valid) begin
        rd++;
        chk("frm_data", 32'(ifm_out), 32'(rd));
        chk("frm_last", 32'(row_last), 32'(rd % IFM_SIZE == 0));
        if (row_last) rl_cnt++;
        $display("frame pixel %0d = %0d last=%0d fd=%0d", rd, ifm_out, row_last, frame_done);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_at = rd;
      end
    end
    in_valid = 1'b0;
    ifm_read = 1'b0;
    chk("frm_pixels",     32'(rd),     32'(IFM_SIZE * IFM_SIZE * CI));
    chk("frm_throughput", 32'(cyc <= 252), 32'd1);
    chk("frm_rows",       32'(rl_cnt), 32'(IFM_SIZE * CI));
    chk("frm_fd_count",   32'(fd_cnt), 32'd1);
    chk("frm_fd_at",      32'(fd_at),  32'(IFM_SIZE * IFM_SIZE * CI));
    chk("frm_underrun",   32'(underrun), 32'd0);
    step();
    chk("frm_fd_pulse",   32'(frame_done), 32'd0);

    // ---------------- underrun ----------------
    do_reset();
    ifm_read = 1'b1;
    chk("ur_full", 32'(full), 32'd0);
    step();
    ifm_read = 1'b0;
    chk("ur_out_valid", 32'(ifm_out_valid), 32'd0);
    chk("ur_flag",      32'(underrun),      32'd1);
    step();
    chk("ur_sticky",    32'(underrun),      32'd1);
    for (int i = 0; i < IFM_SIZE; i++) write_px(8'(50 + i));
    for (int r = 0; r < IFM_SIZE; r++) read_px("ur_row", 8'(50 + r), (r == IFM_SIZE - 1));
    chk("ur_sticky_end", 32'(underrun), 32'd1);

    // ---------------- reset mid-row ----------------
    do_reset();
    for (int i = 0; i < 5; i++) write_px(8'(1 + i));
    #2 rst_n = 1'b0;
    #2;
    chk("mr_full_in_rst", 32'(full), 32'd0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < IFM_SIZE; i++) begin
      chk("mr_not_full", 32'(full), 32'd0);
      write_px(8'(70 + i));
    end
    chk("mr_full_after_9", 32'(full), 32'd1);
    for (int r = 0; r < IFM_SIZE; r++) read_px("mr_row", 8'(70 + r), (r == IFM_SIZE - 1));

    // ---------------- random stalls vs read bursts ----------------
    do_reset();
    pushed = 0; popped = 0; cyc = 0; rd_en = 1'b0;
    while (popped < 5 * IFM_SIZE && cyc < 3000) begin
      in_valid = (pushed < 5 * IFM_SIZE) && ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rd_en = !rd_en;
      ifm_read = full && rd_en;
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        pushed++;
      end
      step();
      cyc++;
      if (ifm_out_valid) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_read", 32'd1, 32'd0);
        end else begin
          exp_px = sb.pop_front();
          chk("rnd_data", 32'(ifm_out), 32'(exp_px));
          $display("rnd pixel %0d = %0d", popped, ifm_out);
        end
        popped++;
      end
    end
    in_valid = 1'b0;
    ifm_read = 1'b0;
    chk("rnd_popped",   32'(popped),    32'(5 * IFM_SIZE));
    chk("rnd_sb_empty", 32'(sb.size()), 32'd0);
    chk("rnd_underrun", 32'(underrun),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
